// File: rtl/sm83_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sm83_bus_ctrl_if
// Brief    : CPU-side handshake and SRAM-side port bundle for sm83_bus_ctrl.
//            master = CPU + SRAM device side, slave = the bus controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sm83_bus_ctrl_if #(
  parameter int SRAM_AW = 13
);
  logic               CPU_REQ;
  logic               CPU_WE;
  logic [15:0]        CPU_ADDR;
  logic [7:0]         CPU_WDATA;
  logic [7:0]         CPU_RDATA;
  logic               CPU_ACK;
  logic [SRAM_AW-1:0] SRAM_ADDRESS;
  logic [7:0]         SRAM_DATA;
  logic [7:0]         SRAM_Q;
  logic               SRAM_WREN;
  logic [7:0]         IE_REG;

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, SRAM_Q,
    input  CPU_RDATA, CPU_ACK, SRAM_ADDRESS, SRAM_DATA, SRAM_WREN, IE_REG
  );

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, SRAM_Q,
    output CPU_RDATA, CPU_ACK, SRAM_ADDRESS, SRAM_DATA, SRAM_WREN, IE_REG
  );
endinterface
`default_nettype wire

// File: rtl/sm83_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sm83_bus_ctrl
// Brief    : SM83 CPU bus controller. Decodes IE (FFFF), HRAM (FF80-FFFE),
//            external synchronous SRAM window and open bus. Optional echo RAM
//            alias E000-FDFF enabled by macro SM83_ECHO_RAM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sm83_bus_ctrl #(
  parameter int          SRAM_AW   = 13,
  parameter logic [15:0] SRAM_BASE = 16'hC000,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input  wire logic      CLOCK,
  input  wire logic      RESET,
  sm83_bus_ctrl_if.slave bus
);

  localparam logic [2:0]  S_IDLE    = 3'd0;
  localparam logic [2:0]  S_RD_ADDR = 3'd1;
  localparam logic [2:0]  S_RD_WAIT = 3'd2;
  localparam logic [2:0]  S_WR      = 3'd3;
  localparam logic [2:0]  S_DONE    = 3'd4;

  localparam logic [16:0] c_SRAM_SPAN  = 17'(2 ** SRAM_AW);
  localparam logic [15:0] c_IE_ADDR    = 16'hFFFF;
  localparam logic [15:0] c_HRAM_LO    = 16'hFF80;
  localparam logic [15:0] c_ECHO_LO    = 16'hE000;
  localparam logic [15:0] c_ECHO_HI    = 16'hFDFF;
  localparam int          c_HRAM_DEPTH = 127;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [7:0]         r_rdata;
  logic [7:0]         r_ie;
  logic [7:0]         r_sram_data;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [7:0]         r_hram [0:c_HRAM_DEPTH-1];
  logic               w_ack;
  logic               w_wren;

  logic               w_is_ie;
  logic               w_is_hram;
  logic               w_sram_hit;
  logic               w_echo_hit;
  logic               w_is_sram;
  logic [16:0]        w_diff;
  logic [SRAM_AW-1:0] w_sram_off;
  logic [6:0]         w_hram_idx;
  logic               w_accept;

  // Address decode in priority order: IE, HRAM, SRAM window, echo, open bus.
  // The 17-bit difference wraps above the span when ADDR < SRAM_BASE.
  assign w_diff     = {1'b0, bus.CPU_ADDR} - {1'b0, SRAM_BASE};
  assign w_is_ie    = (bus.CPU_ADDR == c_IE_ADDR);
  assign w_is_hram  = !w_is_ie && (bus.CPU_ADDR >= c_HRAM_LO);
  assign w_sram_hit = !w_is_ie && !w_is_hram && (w_diff < c_SRAM_SPAN);
  assign w_hram_idx = bus.CPU_ADDR[6:0];

`ifdef SM83_ECHO_RAM_EN
  assign w_echo_hit = !w_is_ie && !w_is_hram && !w_sram_hit &&
                      (bus.CPU_ADDR >= c_ECHO_LO) && (bus.CPU_ADDR <= c_ECHO_HI);
  assign w_sram_off = w_sram_hit ?
                      (bus.CPU_ADDR[SRAM_AW-1:0] - SRAM_BASE[SRAM_AW-1:0]) :
                      (bus.CPU_ADDR[SRAM_AW-1:0] - c_ECHO_LO[SRAM_AW-1:0]);
`else
  assign w_echo_hit = 1'b0;
  assign w_sram_off = bus.CPU_ADDR[SRAM_AW-1:0] - SRAM_BASE[SRAM_AW-1:0];
`endif

  assign w_is_sram = w_sram_hit || w_echo_hit;
  assign w_accept  = (r_state == S_IDLE) && bus.CPU_REQ;

  // State register.
  always_ff @(posedge CLOCK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: SRAM accesses take the slow path, everything else
  // completes straight into DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.CPU_REQ) begin
          if (w_is_sram) w_next = bus.CPU_WE ? S_WR : S_RD_ADDR;
          else           w_next = S_DONE;
        end
      end
      S_RD_ADDR: w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = S_DONE;
      S_WR:      w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    w_ack  = 1'b0;
    w_wren = 1'b0;
    case (r_state)
      S_DONE:  w_ack  = 1'b1;
      S_WR:    w_wren = 1'b1;
      default: begin
        w_ack  = 1'b0;
        w_wren = 1'b0;
      end
    endcase
  end

  // Datapath: SRAM address/data load on accept, fast-path reads and IE
  // writes on the accepting edge, SRAM read data captured leaving RD_WAIT.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_rdata     <= 8'h00;
      r_ie        <= 8'h00;
      r_sram_addr <= '0;
      r_sram_data <= 8'h00;
    end else begin
      if (w_accept && w_is_sram) begin
        r_sram_addr <= w_sram_off;
        if (bus.CPU_WE) r_sram_data <= bus.CPU_WDATA;
      end
      if (w_accept && !w_is_sram) begin
        if (bus.CPU_WE) begin
          if (w_is_ie) r_ie <= bus.CPU_WDATA;
        end else begin
          if (w_is_ie)        r_rdata <= r_ie;
          else if (w_is_hram) r_rdata <= r_hram[w_hram_idx];
          else                r_rdata <= OPEN_BUS;
        end
      end
      if (r_state == S_RD_WAIT) r_rdata <= bus.SRAM_Q;
    end
  end

  // HRAM storage keeps its contents across reset; writes are blocked while
  // reset is asserted so a held request cannot sneak in.
  always_ff @(posedge CLOCK) begin
    if (!RESET && w_accept && w_is_hram && bus.CPU_WE)
      r_hram[w_hram_idx] <= bus.CPU_WDATA;
  end

  assign bus.CPU_RDATA    = r_rdata;
  assign bus.CPU_ACK      = w_ack;
  assign bus.SRAM_ADDRESS = r_sram_addr;
  assign bus.SRAM_DATA    = r_sram_data;
  assign bus.SRAM_WREN    = w_wren;
  assign bus.IE_REG       = r_ie;

endmodule
`default_nettype wire

// File: tb/tb_sm83_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm83_bus_ctrl
// Brief    : Self-checking bench for sm83_bus_ctrl with a transaction-level
//            reference model and a synchronous SRAM device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm83_bus_ctrl;

  localparam int K_IE = 0, K_HRAM = 1, K_SRAM = 2, K_UNM = 3;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;

  sm83_bus_ctrl_if #(.SRAM_AW(13)) u_bus ();

  sm83_bus_ctrl #(.SRAM_AW(13), .SRAM_BASE(16'hC000), .OPEN_BUS(8'hFF)) u_dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (u_bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_wren   = 0;
  int n_ack    = 0;
  bit chk_en   = 1'b0;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 151 + (i >> 5) * 7) ^ 8'h3C;
  endfunction

  // Synchronous SRAM device: registered read, write on WREN.
  logic [7:0] phys [0:8191];
  bit         phys_init = 1'b0;
  always @(posedge CLOCK) begin
    if (!phys_init) begin
      for (int i = 0; i < 8192; i++) phys[i] <= init_val(i);
      phys_init <= 1'b1;
    end else if (u_bus.SRAM_WREN) begin
      phys[u_bus.SRAM_ADDRESS] <= u_bus.SRAM_DATA;
    end
    u_bus.SRAM_Q <= phys[u_bus.SRAM_ADDRESS];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int kind_of(input logic [15:0] a);
    if (a == 16'hFFFF) return K_IE;
    if (a >= 16'hFF80) return K_HRAM;
    if (int'(a) >= 'hC000 && int'(a) < 'hC000 + 8192) return K_SRAM;
`ifdef SM83_ECHO_RAM_EN
    if (a >= 16'hE000 && a <= 16'hFDFF) return K_SRAM;
`endif
    return K_UNM;
  endfunction

  function automatic int off_of(input logic [15:0] a);
    if (int'(a) >= 'hC000 && int'(a) < 'hC000 + 8192) return int'(a) - 'hC000;
    return (int'(a) - 'hE000) % 8192;
  endfunction

  logic [7:0]  m_sram [0:8191];
  logic [7:0]  m_hram [0:126];
  bit          m_hvalid [0:126];
  int          m_k = 0, m_L = 1, m_kind = K_UNM, m_off = 0;
  bit          m_we = 1'b0;
  logic [15:0] m_a = '0;
  logic [7:0]  m_wd = '0, m_ie = '0, m_rdata = '0, m_sdata = '0;
  logic [12:0] m_saddr = '0;
  bit          m_rd_known = 1'b1;

  task automatic model_read();
    m_rd_known = 1'b1;
    case (m_kind)
      K_IE:   m_rdata = m_ie;
      K_HRAM: begin
        if (m_hvalid[int'(m_a) - 'hFF80]) m_rdata = m_hram[int'(m_a) - 'hFF80];
        else m_rd_known = 1'b0;
      end
      K_SRAM: m_rdata = m_sram[m_off];
      default: m_rdata = 8'hFF;
    endcase
  endtask

  // m_k counts cycles since acceptance (0 = able to accept); m_L is the
  // access latency, so the ACK cycle is the one where m_k == m_L.
  initial begin
    for (int i = 0; i < 8192; i++) m_sram[i] = init_val(i);
    for (int i = 0; i < 127; i++) m_hvalid[i] = 1'b0;
    forever begin
      @(posedge CLOCK);
      cyc++;
      if (RESET) begin
        m_k = 0; m_ie = '0; m_rdata = '0; m_rd_known = 1'b1;
        m_saddr = '0; m_sdata = '0;
      end else if (m_k == 0) begin
        if (u_bus.CPU_REQ) begin
          m_a    = u_bus.CPU_ADDR;
          m_we   = u_bus.CPU_WE;
          m_wd   = u_bus.CPU_WDATA;
          m_kind = kind_of(m_a);
          m_L    = (m_kind == K_SRAM) ? (m_we ? 2 : 3) : 1;
          if (m_kind == K_SRAM) begin
            m_off   = off_of(m_a);
            m_saddr = 13'(m_off);
            if (m_we) begin
              m_sdata        = m_wd;
              m_sram[m_off]  = m_wd;
            end
          end else if (m_we) begin
            if (m_kind == K_IE) m_ie = m_wd;
            else if (m_kind == K_HRAM) begin
              m_hram[int'(m_a) - 'hFF80]   = m_wd;
              m_hvalid[int'(m_a) - 'hFF80] = 1'b1;
            end
          end
          m_k = 1;
          if (m_L == 1 && !m_we) model_read();
        end
      end else if (m_k == m_L) begin
        m_k = 0;
      end else begin
        m_k++;
        if (m_k == m_L && !m_we) model_read();
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (u_bus.SRAM_WREN) n_wren++;
      if (u_bus.CPU_ACK)   n_ack++;
      if (chk_en) begin
        check("ack",       32'(u_bus.CPU_ACK),      32'(m_k != 0 && m_k == m_L));
        check("wren",      32'(u_bus.SRAM_WREN),    32'(m_k == 1 && m_kind == K_SRAM && m_we));
        check("sram_addr", 32'(u_bus.SRAM_ADDRESS), 32'(m_saddr));
        check("sram_data", 32'(u_bus.SRAM_DATA),    32'(m_sdata));
        check("ie_reg",    32'(u_bus.IE_REG),       32'(m_ie));
        if (m_rd_known) check("rdata", 32'(u_bus.CPU_RDATA), 32'(m_rdata));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input bit we, input logic [15:0] a, input logic [7:0] d,
                        input bit keep, output int lat, output logic [7:0] rd,
                        output int ack_cyc);
    u_bus.CPU_REQ   = 1'b1;
    u_bus.CPU_WE    = we;
    u_bus.CPU_ADDR  = a;
    u_bus.CPU_WDATA = d;
    lat = 0; rd = '0; ack_cyc = 0;
    forever begin
      @(negedge CLOCK);
      lat++;
      if (u_bus.CPU_ACK) begin
        rd = u_bus.CPU_RDATA;
        ack_cyc = cyc;
        break;
      end
      if (lat > 20) begin
        n_assert++; n_fail++;
        $display("FAIL ack_timeout: no ACK for addr %0h after %0d cycles", a, lat);
        break;
      end
    end
    if (!keep) u_bus.CPU_REQ = 1'b0;
  endtask

  initial begin
    int lat, ac1, ac2, w0, a0;
    logic [7:0] rd, rd2;
    logic [15:0] edges [0:8];
    edges = '{16'hBFFF, 16'hC000, 16'hDFFF, 16'hE000, 16'hFDFF,
              16'hFE00, 16'hFF7F, 16'hFF80, 16'hFFFE};
    u_bus.CPU_REQ = 1'b0; u_bus.CPU_WE = 1'b0;
    u_bus.CPU_ADDR = '0;  u_bus.CPU_WDATA = '0;
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    check("rst_ack",  32'(u_bus.CPU_ACK), 0);
    check("rst_wren", 32'(u_bus.SRAM_WREN), 0);
    check("rst_rdata", 32'(u_bus.CPU_RDATA), 0);
    check("rst_saddr", 32'(u_bus.SRAM_ADDRESS), 0);
    check("rst_sdata", 32'(u_bus.SRAM_DATA), 0);
    check("rst_ie",    32'(u_bus.IE_REG), 0);
    RESET = 1'b0;
    chk_en = 1'b1;
    @(negedge CLOCK);

    // SRAM read of byte 0 (initial content 8'h3C).
    access(1'b0, 16'hC000, 8'h00, 1'b0, lat, rd, ac1);
    check("rd_c000_lat", 32'(lat), 3);
    check("rd_c000_data", 32'(rd), 32'h3C);
    check("rd_c000_saddr", 32'(u_bus.SRAM_ADDRESS), 0);
    @(negedge CLOCK);

    // SRAM write at the top of the window.
    w0 = n_wren;
    access(1'b1, 16'hDFFF, 8'hA5, 1'b0, lat, rd, ac1);
    check("wr_dfff_lat", 32'(lat), 2);
    check("wr_dfff_saddr", 32'(u_bus.SRAM_ADDRESS), 32'h1FFF);
    check("wr_dfff_sdata", 32'(u_bus.SRAM_DATA), 32'hA5);
    check("wr_dfff_pulses", 32'(n_wren - w0), 1);
    @(negedge CLOCK);

    // HRAM write/readback, IE write, HRAM untouched by IE.
    access(1'b1, 16'hFF80, 8'h5A, 1'b0, lat, rd, ac1);
    check("wr_ff80_lat", 32'(lat), 1);
    @(negedge CLOCK);
    access(1'b0, 16'hFF80, 8'h00, 1'b0, lat, rd, ac1);
    check("rd_ff80_lat", 32'(lat), 1);
    check("rd_ff80_data", 32'(rd), 32'h5A);
    @(negedge CLOCK);
    access(1'b1, 16'hFFFF, 8'h1F, 1'b0, lat, rd, ac1);
    check("wr_ie_lat", 32'(lat), 1);
    check("ie_value", 32'(u_bus.IE_REG), 32'h1F);
    @(negedge CLOCK);
    access(1'b0, 16'hFF80, 8'h00, 1'b0, lat, rd, ac1);
    check("hram_after_ie", 32'(rd), 32'h5A);
    @(negedge CLOCK);

    // Unmapped and echo window.
    access(1'b0, 16'h0100, 8'h00, 1'b0, lat, rd, ac1);
    check("rd_0100_data", 32'(rd), 32'hFF);
    check("rd_0100_lat", 32'(lat), 1);
    @(negedge CLOCK);
    w0 = n_wren;
    access(1'b0, 16'hE010, 8'h00, 1'b0, lat, rd, ac1);
`ifdef SM83_ECHO_RAM_EN
    check("echo_saddr", 32'(u_bus.SRAM_ADDRESS), 32'h0010);
    check("echo_lat", 32'(lat), 3);
`else
    check("echo_off_data", 32'(rd), 32'hFF);
    check("echo_off_saddr", 32'(u_bus.SRAM_ADDRESS), 32'h1FFF);
    check("echo_off_lat", 32'(lat), 1);
`endif
    check("echo_no_wren", 32'(n_wren - w0), 0);
    @(negedge CLOCK);

    // Back-to-back reads with CPU_REQ held high.
    a0 = n_ack;
    access(1'b0, 16'hFF80, 8'h00, 1'b1, lat, rd, ac1);
    access(1'b0, 16'hFFFF, 8'h00, 1'b0, lat, rd2, ac2);
    check("b2b_gap", 32'(ac2 - ac1), 2);
    check("b2b_acks", 32'(n_ack - a0), 2);
    check("b2b_rd1", 32'(rd), 32'h5A);
    check("b2b_rd2", 32'(rd2), 32'h1F);
    @(negedge CLOCK);

    // Reset during WR, request held through reset release.
    u_bus.CPU_REQ = 1'b1; u_bus.CPU_WE = 1'b1;
    u_bus.CPU_ADDR = 16'hC005; u_bus.CPU_WDATA = 8'h77;
    @(negedge CLOCK);
    check("wr_state_wren", 32'(u_bus.SRAM_WREN), 1);
    a0 = n_ack;
    RESET = 1'b1;
    @(negedge CLOCK);
    check("rst_mid_wren", 32'(u_bus.SRAM_WREN), 0);
    check("rst_mid_ack", 32'(u_bus.CPU_ACK), 0);
    check("rst_mid_ie", 32'(u_bus.IE_REG), 0);
    RESET = 1'b0;
    access(1'b1, 16'hC005, 8'h77, 1'b0, lat, rd, ac1);
    check("post_rst_lat", 32'(lat), 2);
    check("post_rst_acks", 32'(n_ack - a0), 1);
    @(negedge CLOCK);

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      logic [15:0] a;
      int sel, gap;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: a = 16'(16'hC000 + $urandom_range(0, 8191));
        1: a = 16'(16'hFF80 + $urandom_range(0, 126));
        2: a = 16'hFFFF;
        3: a = 16'($urandom);
        4: a = 16'(16'hE000 + $urandom_range(0, 16'h1DFF));
        default: a = edges[$urandom_range(0, 8)];
      endcase
      gap = int'($urandom_range(0, 2));
      access(1'($urandom), a, 8'($urandom), (gap == 0), lat, rd, ac1);
      if ($urandom_range(0, 39) == 0) begin
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
      end
      repeat (gap) @(negedge CLOCK);
    end
    u_bus.CPU_REQ = 1'b0;
    repeat (4) @(negedge CLOCK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
